// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream packet arbiter family.
package axis_arb_pkg;

  localparam int AXIS_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // Next index in a ring of n entries, wrapping n-1 back to 0.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: first requester strictly after 'last',
// wrapping around so 'last' itself is considered only after everyone else.
module axis_rr_pick
  import axis_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] pick,
  output logic         any_req
);

  int idx;

  always_comb begin
    pick    = last;
    any_req = 1'b0;
    idx     = rr_next(int'(last), N);
    for (int i = 0; i < N; i++) begin
      if (!any_req && req[idx]) begin
        pick    = W'(idx);
        any_req = 1'b1;
      end
      idx = rr_next(idx, N);
    end
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin AXI-Stream arbiter with a registered output stage
// and a per-packet beat limit that truncates runaway packets.
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int MAX_BEATS = 1024,
  parameter int SRC_W     = $clog2(NUM_SRC)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC*AXIS_DW-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]         s_tvalid,
  output logic [NUM_SRC-1:0]         s_tready,
  input  logic [NUM_SRC-1:0]         s_tlast,
  input  logic [NUM_SRC-1:0]         s_tuser,
  output logic [AXIS_DW-1:0]         m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tlast,
  output logic                       m_tuser,
  output logic [SRC_W-1:0]           grant_idx,
  output logic                       busy,
  output logic                       trunc_pulse,
  output logic [15:0]                pkt_count
);

  localparam int CNT_W = $clog2(MAX_BEATS);

  arb_state_t         state;
  logic [CNT_W-1:0]   beat_cnt;
  logic               load_en;
  logic [AXIS_DW-1:0] sel_data;
  logic               sel_valid;
  logic               sel_last;
  logic               sel_user;
  logic               at_limit;
  logic               grant_hs;
  logic [SRC_W-1:0]   pick_idx;
  logic               any_req;

  axis_rr_pick #(
    .N (NUM_SRC),
    .W (SRC_W)
  ) u_pick (
    .req     (s_tvalid),
    .last    (grant_idx),
    .pick    (pick_idx),
    .any_req (any_req)
  );

  assign load_en   = !m_tvalid || m_tready;
  assign sel_data  = s_tdata[AXIS_DW*grant_idx +: AXIS_DW];
  assign sel_valid = s_tvalid[grant_idx];
  assign sel_last  = s_tlast[grant_idx];
  assign sel_user  = s_tuser[grant_idx];
  assign at_limit  = (beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign grant_hs  = (state == GRANT) && sel_valid && load_en;
  assign busy      = (state != IDLE);

  // Only the granted source sees ready; while draining it is swallowed unconditionally.
  always_comb begin
    s_tready = '0;
    if (state == GRANT) begin
      s_tready[grant_idx] = load_en;
    end else if (state == DRAIN) begin
      s_tready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant_idx   <= SRC_W'(NUM_SRC - 1);
      beat_cnt    <= '0;
      m_tdata     <= '0;
      m_tvalid    <= 1'b0;
      m_tlast     <= 1'b0;
      m_tuser     <= 1'b0;
      trunc_pulse <= 1'b0;
      pkt_count   <= '0;
    end else begin
      trunc_pulse <= 1'b0;

      if (m_tvalid && m_tready && m_tlast) begin
        pkt_count <= pkt_count + 16'd1;
      end

      // A beat hitting the limit without tlast is forced to close the packet and flagged in tuser.
      if (grant_hs) begin
        m_tdata  <= sel_data;
        m_tvalid <= 1'b1;
        m_tlast  <= sel_last || at_limit;
        m_tuser  <= sel_user || (at_limit && !sel_last);
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (any_req) begin
            grant_idx <= pick_idx;
            beat_cnt  <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (grant_hs) begin
            if (sel_last) begin
              beat_cnt <= '0;
              state    <= IDLE;
            end else if (at_limit) begin
              beat_cnt    <= '0;
              trunc_pulse <= 1'b1;
              state       <= DRAIN;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (sel_valid && sel_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Bench for axis_pkt_arbiter: directed scenarios plus randomized traffic compared
// against a queue-based round-robin packet model.
module tb_axis_pkt_arbiter;

  localparam int NUM_SRC   = 4;
  localparam int MAX_BEATS = 4;
  localparam int SW        = $clog2(NUM_SRC);
  localparam int DW        = 32;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        user;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        user;
    int          cyc;
  } obs_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_SRC*DW-1:0] s_tdata;
  logic [NUM_SRC-1:0]    s_tvalid, s_tready, s_tlast, s_tuser;
  logic [31:0]           m_tdata;
  logic                  m_tvalid, m_tready, m_tlast, m_tuser;
  logic [SW-1:0]         grant_idx;
  logic                  busy, trunc_pulse;
  logic [15:0]           pkt_count;

  int          tests_run = 0;
  int          tests_failed = 0;
  beat_t       src_q[NUM_SRC][$];
  int          gap[NUM_SRC];
  beat_t       exp_q[$];
  obs_t        obs_q[$];
  int          model_last;
  logic [15:0] exp_pkt;
  int          exp_trunc, exp_npkts;
  int          trunc_seen, stall_err;

  axis_pkt_arbiter #(.NUM_SRC(NUM_SRC), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tuser(s_tuser), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .m_tuser(m_tuser), .grant_idx(grant_idx),
    .busy(busy), .trunc_pulse(trunc_pulse), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_reset();
    rst = 1'b1; s_tvalid = '0; s_tdata = '0; s_tlast = '0; s_tuser = '0; m_tready = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin src_q[i].delete(); gap[i] = 0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_last = NUM_SRC - 1;
    exp_pkt = '0;
  endtask

  task automatic add_packet(input int src, input int len, input int id, input bit rnd_user);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = {8'(src), 8'(id), 16'(k)};
      b.last = (k == len - 1);
      b.user = rnd_user ? 1'($urandom_range(0, 1)) : 1'b0;
      src_q[src].push_back(b);
    end
  endtask

  task automatic drive_sources();
    beat_t b;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_q[i].size() > 0 && gap[i] == 0) begin
        b = src_q[i][0];
        s_tvalid[i] = 1'b1; s_tdata[i*DW +: DW] = b.data; s_tlast[i] = b.last; s_tuser[i] = b.user;
      end else begin
        s_tvalid[i] = 1'b0; s_tdata[i*DW +: DW] = '0; s_tlast[i] = 1'b0; s_tuser[i] = 1'b0;
      end
    end
  endtask

  // Reference: whole packets leave in round-robin order over non-empty sources;
  // packets longer than MAX_BEATS are cut at MAX_BEATS with last=1, user=1.
  task automatic build_expected();
    beat_t mq[NUM_SRC][$];
    beat_t b, d;
    int    k, c, beats;
    bit    done;
    exp_q.delete(); exp_trunc = 0; exp_npkts = 0;
    for (int i = 0; i < NUM_SRC; i++) mq[i] = src_q[i];
    forever begin
      k = -1;
      for (int j = 1; j <= NUM_SRC; j++) begin
        c = (model_last + j) % NUM_SRC;
        if (k < 0 && mq[c].size() > 0) k = c;
      end
      if (k < 0) break;
      beats = 0; done = 0;
      while (!done && mq[k].size() > 0) begin
        b = mq[k].pop_front(); beats++;
        if (b.last) begin
          exp_q.push_back(b); done = 1;
        end else if (beats == MAX_BEATS) begin
          b.last = 1'b1; b.user = 1'b1; exp_q.push_back(b); exp_trunc++;
          while (mq[k].size() > 0) begin d = mq[k].pop_front(); if (d.last) break; end
          done = 1;
        end else begin
          exp_q.push_back(b);
        end
      end
      model_last = k; exp_npkts++;
    end
    exp_pkt = exp_pkt + 16'(exp_npkts);
  endtask

  task automatic run_traffic(input int max_cycles, input int ready_pct, input int gap_pct,
                             output bit timed_out);
    int          n;
    bit          hs[NUM_SRC];
    bit          prev_stall, idle;
    logic [31:0] hold_d;
    logic        hold_l, hold_u;
    beat_t       b;
    obs_t        o;
    obs_q.delete(); trunc_seen = 0; stall_err = 0; timed_out = 0; n = 0; prev_stall = 0;
    hold_d = '0; hold_l = 1'b0; hold_u = 1'b0;
    m_tready = ($urandom_range(0, 99) < ready_pct);
    drive_sources();
    forever begin
      @(negedge clk);
      if (m_tvalid && m_tready) begin
        o.data = m_tdata; o.last = m_tlast; o.user = m_tuser; o.cyc = n; obs_q.push_back(o);
      end
      if (trunc_pulse) trunc_seen++;
      if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== hold_d || m_tlast !== hold_l || m_tuser !== hold_u))
        stall_err++;
      prev_stall = m_tvalid && !m_tready;
      hold_d = m_tdata; hold_l = m_tlast; hold_u = m_tuser;
      for (int i = 0; i < NUM_SRC; i++) hs[i] = s_tvalid[i] && s_tready[i];
      @(posedge clk); #1;
      n++;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (hs[i]) begin
          b = src_q[i].pop_front();
          gap[i] = (!b.last && $urandom_range(0, 99) < gap_pct) ? int'($urandom_range(1, 3)) : 0;
        end else if (gap[i] > 0) begin
          gap[i]--;
        end
      end
      idle = !m_tvalid && !busy && !trunc_pulse;
      for (int i = 0; i < NUM_SRC; i++) if (src_q[i].size() > 0) idle = 0;
      if (idle) break;
      if (n >= max_cycles) begin timed_out = 1; break; end
      m_tready = ($urandom_range(0, 99) < ready_pct);
      drive_sources();
    end
    s_tvalid = '0; m_tready = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests_run++;
    if (m_tvalid !== 1'b0 || m_tdata !== 32'h0 || m_tlast !== 1'b0 || m_tuser !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_m: got v=%b d=%h l=%b u=%b, expected all zero", m_tvalid, m_tdata, m_tlast, m_tuser);
    end
    tests_run++;
    if (s_tready !== 4'b0000) begin
      tests_failed++; $display("[TB] FAIL reset_s_tready: got %b, expected 0000", s_tready);
    end
    tests_run++;
    if (grant_idx !== 2'd3) begin
      tests_failed++; $display("[TB] FAIL reset_grant_idx: got %0d, expected 3", grant_idx);
    end
    tests_run++;
    if (busy !== 1'b0 || trunc_pulse !== 1'b0 || pkt_count !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_status: got busy=%b trunc=%b cnt=%0d, expected 0 0 0", busy, trunc_pulse, pkt_count);
    end
  endtask

  task automatic test_single_source();
    int b = 0, exp_out = -1;
    bit hs, done = 0;
    m_tready = 1'b1;
    s_tvalid[2] = 1'b1; s_tdata[2*DW +: DW] = 32'd0; s_tlast[2] = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      tests_run++;
      if (exp_out < 0 && m_tvalid !== 1'b0) begin
        tests_failed++; $display("[TB] FAIL single_idle_valid: got m_tvalid=%b, expected 0", m_tvalid);
      end else if (exp_out >= 0 && (m_tvalid !== 1'b1 || m_tdata !== 32'(exp_out) || m_tlast !== (exp_out == 2))) begin
        tests_failed++;
        $display("[TB] FAIL single_beat: got v=%b d=%0d l=%b, expected v=1 d=%0d l=%b",
                 m_tvalid, m_tdata, m_tlast, exp_out, exp_out == 2);
      end
      if (exp_out == 2) begin
        tests_run++;
        if (busy !== 1'b0) begin
          tests_failed++; $display("[TB] FAIL single_busy: got %b, expected 0 after tlast", busy);
        end
        done = 1;
      end
      hs = s_tvalid[2] && s_tready[2];
      @(posedge clk); #1;
      if (hs) begin
        exp_out = b; b++;
        if (b < 3) begin s_tdata[2*DW +: DW] = 32'(b); s_tlast[2] = (b == 2); end
        else begin s_tvalid[2] = 1'b0; s_tlast[2] = 1'b0; end
      end else begin
        exp_out = -1;
      end
    end
    tests_run++;
    if (!done) begin tests_failed++; $display("[TB] FAIL single_timeout: got %0d beats, expected 3", b); end
    @(negedge clk);
    tests_run++;
    if (grant_idx !== 2'd2 || pkt_count !== 16'd1) begin
      tests_failed++; $display("[TB] FAIL single_final: got grant=%0d cnt=%0d, expected 2 1", grant_idx, pkt_count);
    end
    model_last = 2; exp_pkt = 16'd1;
  endtask

  task automatic test_round_robin();
    bit to;
    int eg;
    do_reset();
    for (int p = 0; p < 2; p++) for (int s = 0; s < NUM_SRC; s++) add_packet(s, 2, p, 1);
    build_expected();
    run_traffic(300, 100, 0, to);
    tests_run++;
    if (to || obs_q.size() != exp_q.size()) begin
      tests_failed++; $display("[TB] FAIL rr_count: got %0d beats (timeout=%b), expected %0d", obs_q.size(), to, exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last || obs_q[i].user !== exp_q[i].user) begin
        tests_failed++;
        $display("[TB] FAIL rr_beat %0d: got %h/%b/%b, expected %h/%b/%b", i, obs_q[i].data, obs_q[i].last,
                 obs_q[i].user, exp_q[i].data, exp_q[i].last, exp_q[i].user);
      end
    end
    if (obs_q.size() == 16) begin
      for (int p = 0; p < 8; p++) begin
        tests_run++;
        if (obs_q[2*p].data[31:24] !== 8'(p % NUM_SRC)) begin
          tests_failed++; $display("[TB] FAIL rr_order %0d: got src %0d, expected %0d", p, obs_q[2*p].data[31:24], p % NUM_SRC);
        end
      end
      for (int i = 1; i < 16; i++) begin
        eg = obs_q[i-1].last ? 2 : 1;
        tests_run++;
        if (obs_q[i].cyc - obs_q[i-1].cyc != eg) begin
          tests_failed++; $display("[TB] FAIL rr_spacing %0d: got %0d cycles, expected %0d", i, obs_q[i].cyc - obs_q[i-1].cyc, eg);
        end
      end
    end
    tests_run++;
    if (pkt_count !== exp_pkt) begin
      tests_failed++; $display("[TB] FAIL rr_pkt_count: got %0d, expected %0d", pkt_count, exp_pkt);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] hold_d;
    logic        hold_l;
    int          stall_hs = 0, n_out = 0, n_tr = 0;
    bit          hs0;
    beat_t       b;
    add_packet(0, 4, 9, 0);
    hold_d = '0; hold_l = 1'b0;
    for (int c = 0; c < 60; c++) begin
      m_tready = !(c >= 3 && c < 8);
      drive_sources();
      @(negedge clk);
      if (trunc_pulse) n_tr++;
      if (m_tvalid && m_tready) begin
        tests_run++;
        if (m_tdata !== {8'd0, 8'd9, 16'(n_out)} || m_tlast !== (n_out == 3) || m_tuser !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL bp_beat %0d: got %h/%b/%b, expected %h/%b/0", n_out, m_tdata, m_tlast, m_tuser,
                   {8'd0, 8'd9, 16'(n_out)}, n_out == 3);
        end
        n_out++;
      end
      if (c == 3) begin hold_d = m_tdata; hold_l = m_tlast; end
      if (c > 3 && c < 8) begin
        tests_run++;
        if (m_tvalid !== 1'b1 || m_tdata !== hold_d || m_tlast !== hold_l) begin
          tests_failed++;
          $display("[TB] FAIL bp_stable c%0d: got v=%b d=%h l=%b, expected v=1 d=%h l=%b", c, m_tvalid, m_tdata, m_tlast, hold_d, hold_l);
        end
      end
      hs0 = s_tvalid[0] && s_tready[0];
      if (hs0 && c >= 3 && c < 8) stall_hs++;
      @(posedge clk); #1;
      if (hs0) b = src_q[0].pop_front();
      if (src_q[0].size() == 0 && !m_tvalid && c > 8) break;
    end
    s_tvalid = '0; m_tready = 1'b1;
    tests_run++;
    if (stall_hs > 1) begin tests_failed++; $display("[TB] FAIL bp_stall_accepts: got %0d, expected <=1", stall_hs); end
    tests_run++;
    if (n_out != 4 || n_tr != 0) begin
      tests_failed++; $display("[TB] FAIL bp_totals: got beats=%0d trunc=%0d, expected 4 0", n_out, n_tr);
    end
    model_last = 0; exp_pkt = exp_pkt + 16'd1;
  endtask

  task automatic test_truncation();
    bit to;
    add_packet(1, 6, 1, 1); add_packet(0, 1, 2, 1); add_packet(2, 1, 3, 1); add_packet(3, 4, 4, 0);
    build_expected();
    run_traffic(300, 100, 0, to);
    tests_run++;
    if (to || obs_q.size() != exp_q.size()) begin
      tests_failed++; $display("[TB] FAIL trunc_count: got %0d beats (timeout=%b), expected %0d", obs_q.size(), to, exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last || obs_q[i].user !== exp_q[i].user) begin
        tests_failed++;
        $display("[TB] FAIL trunc_beat %0d: got %h/%b/%b, expected %h/%b/%b", i, obs_q[i].data, obs_q[i].last,
                 obs_q[i].user, exp_q[i].data, exp_q[i].last, exp_q[i].user);
      end
    end
    if (obs_q.size() >= 5) begin
      tests_run++;
      if (obs_q[3].last !== 1'b1 || obs_q[3].user !== 1'b1 || obs_q[4].data[31:24] !== 8'd2) begin
        tests_failed++;
        $display("[TB] FAIL trunc_marker: got l=%b u=%b next_src=%0d, expected 1 1 2", obs_q[3].last, obs_q[3].user, obs_q[4].data[31:24]);
      end
    end
    tests_run++;
    if (trunc_seen != exp_trunc || pkt_count !== exp_pkt) begin
      tests_failed++;
      $display("[TB] FAIL trunc_pulse: got pulses=%0d cnt=%0d, expected %0d %0d", trunc_seen, pkt_count, exp_trunc, exp_pkt);
    end
  endtask

  task automatic test_reset_mid_packet();
    int    cnt = 0;
    bit    hs, to;
    beat_t b;
    add_packet(1, 4, 5, 1);
    m_tready = 1'b1;
    for (int c = 0; c < 20 && cnt < 2; c++) begin
      drive_sources();
      @(negedge clk);
      hs = s_tvalid[1] && s_tready[1];
      @(posedge clk); #1;
      if (hs) begin b = src_q[1].pop_front(); cnt++; end
    end
    rst = 1'b1; s_tvalid = '0; s_tlast = '0;
    src_q[1].delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (cnt != 2 || m_tvalid !== 1'b0 || s_tready !== 4'b0000 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_state: got beats=%0d v=%b rdy=%b busy=%b, expected 2 0 0000 0", cnt, m_tvalid, s_tready, busy);
    end
    tests_run++;
    if (grant_idx !== 2'd3 || pkt_count !== 16'd0) begin
      tests_failed++; $display("[TB] FAIL rstmid_regs: got grant=%0d cnt=%0d, expected 3 0", grant_idx, pkt_count);
    end
    model_last = NUM_SRC - 1; exp_pkt = '0;
    add_packet(3, 1, 6, 1); add_packet(1, 1, 7, 1); add_packet(0, 1, 8, 1);
    build_expected();
    run_traffic(100, 100, 0, to);
    tests_run++;
    if (to || obs_q.size() != 3 || obs_q[0].data[31:24] !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_first: got %0d beats first_src=%0d, expected 3 beats first_src=0",
               obs_q.size(), (obs_q.size() > 0) ? int'(obs_q[0].data[31:24]) : -1);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last) begin
        tests_failed++; $display("[TB] FAIL rstmid_beat %0d: got %h, expected %h", i, obs_q[i].data, exp_q[i].data);
      end
    end
  endtask

  task automatic test_random();
    bit to;
    int np;
    for (int r = 0; r < 4; r++) begin
      np = $urandom_range(6, 12);
      for (int p = 0; p < np; p++) add_packet($urandom_range(0, NUM_SRC - 1), $urandom_range(1, 6), 16 * r + p, 1);
      build_expected();
      run_traffic(2000, 60, 30, to);
      tests_run++;
      if (to || obs_q.size() != exp_q.size()) begin
        tests_failed++;
        $display("[TB] FAIL rand%0d_count: got %0d beats (timeout=%b), expected %0d", r, obs_q.size(), to, exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        tests_run++;
        if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last || obs_q[i].user !== exp_q[i].user) begin
          tests_failed++;
          $display("[TB] FAIL rand%0d_beat %0d: got %h/%b/%b, expected %h/%b/%b", r, i, obs_q[i].data, obs_q[i].last,
                   obs_q[i].user, exp_q[i].data, exp_q[i].last, exp_q[i].user);
        end
      end
      tests_run++;
      if (trunc_seen != exp_trunc || stall_err != 0 || pkt_count !== exp_pkt) begin
        tests_failed++;
        $display("[TB] FAIL rand%0d_status: got trunc=%0d stall_err=%0d cnt=%0d, expected %0d 0 %0d",
                 r, trunc_seen, stall_err, pkt_count, exp_trunc, exp_pkt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_truncation();
    test_reset_mid_packet();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
